mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_lat_cnt.sv | 20 ++
 rtl/mem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and default memory latency
package mem_arb_pkg;
  localparam int DEF_MEM_LATENCY = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } state_t;
endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt: loadable down-counter flagging when the memory latency has elapsed
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch and data ports.
// Define ARB_PERF_CNT_EN to add saturating per-requester stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       dm_stall_cnt
`endif
);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  state_t r_state;
  logic   r_last_dm;
  logic   w_any, w_grant_dm, w_busy, w_load, w_done;
  assign w_any      = if_req || dm_req;
  assign w_grant_dm = dm_req && (!if_req || !r_last_dm);
  assign w_busy     = r_state == BUSY_IF || r_state == BUSY_DM;
  assign w_load     = r_state == IDLE && w_any;
  assign if_stall   = if_req && !if_valid;
  assign dm_stall   = dm_req && !dm_valid;
  mem_arb_lat_cnt #(.W(CW)) u_lat (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (CW'(MEM_LATENCY - 1)),
    .i_dec   (w_busy),
    .o_done  (w_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_last_dm <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_state   <= w_grant_dm ? BUSY_DM : BUSY_IF;
          r_last_dm <= w_grant_dm;
          mem_en    <= 1'b1;
          mem_we    <= w_grant_dm && dm_we;
          mem_addr  <= w_grant_dm ? dm_addr : if_addr;
          mem_wdata <= w_grant_dm ? dm_wdata : '0;
        end
        // stores capture too; the bus value is simply ignored by the cpu
        BUSY_IF, BUSY_DM: if (w_done) begin
          r_state <= r_state == BUSY_DM ? RESP_DM : RESP_IF;
          if (r_state == BUSY_DM) dm_rdata <= mem_rdata;
          else if_rdata <= mem_rdata;
          if_valid <= r_state == BUSY_IF;
          dm_valid <= r_state == BUSY_DM;
        end
        default: r_state <= IDLE;
      endcase
    end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_stall_cnt <= '0;
      dm_stall_cnt <= '0;
    end else begin
      if (if_stall && ~&if_stall_cnt) if_stall_cnt <= if_stall_cnt + 1'b1;
      if (dm_stall && ~&dm_stall_cnt) dm_stall_cnt <= dm_stall_cnt + 1'b1;
    end
`endif
endmodule
